poly_keybuffer: RTL and testbench
=================================

# poly_keybuffer

Parametrised polyphonic successor to the single/dual-key buffer: captures USB keyboard keycodes into SLOTS independent voice slots, each held for a programmable note duration and refreshed while the key keeps being reported. Sits between the USB keycode reader and the tone generators; each slot drives one voice, and one-hot note-on/note-off strobes are provided for envelope logic.

## Interface
- SLOTS, 4: number of voice slots (2..16)
- KEY_W, 8: keycode width
- HOLD_CYCLES, 2_500_000: note duration in clk cycles after the last report (50 ms at 50 MHz)
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  reset, asynchronous assert, active-low; one clock, reset asynchronous and active-low
- key_valid  in  1  one-cycle strobe: keycode carries a fresh USB report sample
- keycode  in  KEY_W  sampled keycode; 0 = no key
- sustain  in  1  level: while high, hold timers freeze (no expiry)
- clear  in  1  synchronous flush of all slots
- slot_key  out  SLOTS*KEY_W  slot i keycode at [i*KEY_W +: KEY_W]; 0 when inactive
- slot_active  out  SLOTS  slot i holds a note
- note_on  out  SLOTS  one-cycle one-hot strobe: slot allocated or stolen
- note_off  out  SLOTS  one-cycle strobe per slot freed, stolen or cleared (multi-hot allowed)

## Operation
- Per slot: key register, active flag, down-counter timer of width $clog2(HOLD_CYCLES+1).
- key_valid with keycode==0: ignored (slots expire naturally).
- key_valid with keycode!=0, matching active slot i: timer_i reloads HOLD_CYCLES; no strobes.
- No match, free slot exists: lowest-index free slot loads key, timer=HOLD_CYCLES, active=1, note_on[i]=1.
- No match, all full: steal slot with smallest timer (lowest index on tie); note_off[i] and note_on[i] both pulse same cycle; key replaced, timer reloaded.
- Each cycle, active slot with sustain=0 decrements timer; at transition 1->0 slot clears (key=0, active=0), note_off[i]=1.
- clear=1: all active slots freed, note_off = slot_active; key_valid that cycle ignored.
- Match comparison against inactive slots never hits (inactive key is 0, keycode 0 never matched).

## Timing
- Reset: slot_key=0, slot_active=0, note_on=0, note_off=0, timers=0; effective immediately on reset_n low.
- Latency: key_valid at edge n -> slot_active/slot_key/note_on updated after edge n+1 (one register stage, no input pipeline).
- Refresh vs expiry same cycle on same slot: refresh wins; no note_off.
- Allocation vs expiry same cycle: free/full decision uses state before the edge; a slot expiring that cycle is not free yet (steal proceeds if otherwise full).
- Multiple expiries same cycle: all freed, note_off multi-hot.
- sustain high: timers hold value; refresh still reloads; allocation/steal unchanged.
- clear has priority over key_valid and expiry.
- HOLD_CYCLES=1: slot lives exactly one cycle after allocation unless refreshed.

## Structure
- Package keybuf_pkg: KEY_NONE constant (0), keycode_t typedef (KEY_W=8 default), default HOLD_CYCLES.
- Sub-module keybuf_slot: key/active/timer registers, load/refresh/clear inputs, expire output; instanced SLOTS times via generate.
- Top: match detector, lowest-free priority encoder, min-timer steal selector, strobe registers.

## Test plan
- SLOTS=4, HOLD=10: key_valid 0x04 -> next cycle slot0=0x04, note_on=0001; no refresh -> note_off=0001 exactly 10 cycles later.
- 0x04 then 0x16 then 0x04 every 5 cycles: slot0/slot1 allocated once, slot0 never expires while refreshed; no extra note_on.
- Fill 0x04,0x05,0x06,0x07 (one per cycle), then 0x08: slot0 (smallest timer) stolen, note_off=note_on=0001, slot0=0x08.
- sustain high for 30 cycles with 2 slots active: no note_off; after release, expiry resumes from frozen count.
- Refresh arrives on expiry cycle of slot1: slot1 stays active, no note_off; clear with 3 active -> note_off=0111, all slot_key=0.
- reset_n low mid-hold: outputs 0 immediately (asynchronous); after release, 0x04 allocates slot0.

Source files
------------

// File: rtl/keybuf_pkg.sv
// Shared constants and types for the polyphonic key buffer.
// Both the slot sub-module and the top size their timers with timer_width().
package keybuf_pkg;

    localparam int SLOTS_DEF       = 4;
    localparam int KEY_W_DEF       = 8;
    localparam int HOLD_CYCLES_DEF = 2_500_000;

    typedef logic [KEY_W_DEF-1:0] keycode_t;

    localparam keycode_t KEY_NONE = '0;

    // Wide enough to hold the value HOLD_CYCLES itself, never narrower than one bit.
    function automatic int timer_width(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/poly_keybuffer_if.sv
// Keycode input bundle and per-slot voice outputs between the USB reader and the tone generators.
// master drives keycodes and controls; slave is the key buffer.
interface poly_keybuffer_if #(
    parameter int SLOTS = 4,
    parameter int KEY_W = 8
);

    logic                   key_valid;
    logic [KEY_W-1:0]       keycode;
    logic                   sustain;
    logic                   clear;
    logic [SLOTS*KEY_W-1:0] slot_key;
    logic [SLOTS-1:0]       slot_active;
    logic [SLOTS-1:0]       note_on;
    logic [SLOTS-1:0]       note_off;

    modport master (
        output key_valid, keycode, sustain, clear,
        input  slot_key, slot_active, note_on, note_off
    );

    modport slave (
        input  key_valid, keycode, sustain, clear,
        output slot_key, slot_active, note_on, note_off
    );

endinterface

// File: rtl/keybuf_slot.sv
// One voice slot: keycode, active flag and hold down-counter.
// Priority of updates is clear > load > refresh > expiry > countdown.
module keybuf_slot
    import keybuf_pkg::*;
#(
    parameter int KEY_W       = KEY_W_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int TIMER_W     = timer_width(HOLD_CYCLES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load,
    input  logic               refresh,
    input  logic               tick,
    input  logic [KEY_W-1:0]   new_key,
    output logic [KEY_W-1:0]   key,
    output logic               active,
    output logic [TIMER_W-1:0] timer,
    output logic               expire
);

    localparam logic [TIMER_W-1:0] HOLD_T = TIMER_W'(HOLD_CYCLES);
    localparam logic [TIMER_W-1:0] ONE_T  = TIMER_W'(1);

    // Raw expiry: the top decides whether a same-cycle refresh or steal overrides it.
    assign expire = active && tick && (timer == ONE_T);

    // NOTE: state registers use non-blocking assignments so every slot samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key    <= '0;
            active <= 1'b0;
            timer  <= '0;
        end else if (clear) begin
            key    <= '0;
            active <= 1'b0;
            timer  <= '0;
        end else if (load) begin
            key    <= new_key;
            active <= 1'b1;
            timer  <= HOLD_T;
        end else if (refresh) begin
            timer  <= HOLD_T;
        end else if (expire) begin
            key    <= '0;
            active <= 1'b0;
            timer  <= '0;
        end else if (active && tick) begin
            timer  <= timer - ONE_T;
        end
    end

endmodule

// File: rtl/poly_keybuffer.sv
// Polyphonic key buffer: allocates, refreshes, steals and expires SLOTS voice slots
// from a stream of USB keycode samples, with registered note-on/note-off strobes.
module poly_keybuffer
    import keybuf_pkg::*;
#(
    parameter int SLOTS       = SLOTS_DEF,
    parameter int KEY_W       = KEY_W_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    poly_keybuffer_if.slave  bus
);

    localparam int TIMER_W = timer_width(HOLD_CYCLES);
    localparam int IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [KEY_W-1:0]       key_q   [SLOTS];
    logic [TIMER_W-1:0]     timer_q [SLOTS];
    logic [SLOTS-1:0]       active_q;
    logic [SLOTS-1:0]       expire;
    logic [SLOTS-1:0]       hit;
    logic [SLOTS-1:0]       load_vec;
    logic [SLOTS-1:0]       refresh_vec;
    logic [SLOTS-1:0]       note_on_d,  note_off_d;
    logic [SLOTS-1:0]       note_on_q,  note_off_q;
    logic                   req;
    logic                   has_free;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W-1:0]       steal_idx;
    logic [TIMER_W-1:0]     min_timer;
    logic [SLOTS*KEY_W-1:0] slot_key_flat;
    logic                   tick;

    assign tick = !bus.sustain;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        keybuf_slot #(
            .KEY_W       (KEY_W),
            .HOLD_CYCLES (HOLD_CYCLES),
            .TIMER_W     (TIMER_W)
        ) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (bus.clear),
            .load    (load_vec[g]),
            .refresh (refresh_vec[g]),
            .tick    (tick),
            .new_key (bus.keycode),
            .key     (key_q[g]),
            .active  (active_q[g]),
            .timer   (timer_q[g]),
            .expire  (expire[g])
        );

        assign hit[g] = active_q[g] && (key_q[g] == bus.keycode);
    end

    // Lowest-index free slot: scanning downward lets the lowest match overwrite last.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Steal victim: smallest remaining timer, strict compare keeps the lowest index on ties.
    always_comb begin
        steal_idx = '0;
        min_timer = timer_q[0];
        for (int i = 1; i < SLOTS; i++) begin
            if (timer_q[i] < min_timer) begin
                min_timer = timer_q[i];
                steal_idx = IDX_W'(i);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        req         = bus.key_valid && (bus.keycode != KEY_W'(KEY_NONE)) && !bus.clear;
        refresh_vec = req ? hit : '0;
        load_vec    = '0;
        if (req && (hit == '0)) begin
            load_vec[has_free ? free_idx : steal_idx] = 1'b1;
        end
        note_on_d = load_vec;
        // A loaded active slot is a steal; a refreshed or stolen slot suppresses its own expiry.
        if (bus.clear) begin
            note_off_d = active_q;
        end else begin
            note_off_d = (expire & ~refresh_vec & ~load_vec) | (load_vec & active_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            note_on_q  <= '0;
            note_off_q <= '0;
        end else begin
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
        end
    end

    always_comb begin
        slot_key_flat = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_key_flat[i*KEY_W +: KEY_W] = key_q[i];
        end
    end

    assign bus.slot_key    = slot_key_flat;
    assign bus.slot_active = active_q;
    assign bus.note_on     = note_on_q;
    assign bus.note_off    = note_off_q;

endmodule

// File: tb/tb_poly_keybuffer.sv
// Directed bench for poly_keybuffer with SLOTS=4, KEY_W=8, HOLD_CYCLES=10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_poly_keybuffer;
    import keybuf_pkg::*;

    localparam int SLOTS = 4;
    localparam int KEY_W = 8;
    localparam int HOLD  = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    poly_keybuffer_if #(.SLOTS(SLOTS), .KEY_W(KEY_W)) bus ();

    poly_keybuffer #(
        .SLOTS       (SLOTS),
        .KEY_W       (KEY_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int on_cnt;
    int off_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one keycode sample for exactly one rising edge.
    task automatic send(input keycode_t k);
        bus.key_valid = 1'b1;
        bus.keycode   = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.keycode   = KEY_NONE;
    endtask

    task automatic pulse_clear(input keycode_t k);
        bus.clear     = 1'b1;
        bus.key_valid = 1'b1;
        bus.keycode   = k;
        @(negedge clk);
        bus.clear     = 1'b0;
        bus.key_valid = 1'b0;
        bus.keycode   = KEY_NONE;
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.keycode   = KEY_NONE;
        bus.sustain   = 1'b0;
        bus.clear     = 1'b0;

        idle(2);
        check("rst_key",    bus.slot_key,    32'h0);
        check("rst_active", bus.slot_active, 4'b0000);
        check("rst_on",     bus.note_on,     4'b0000);
        check("rst_off",    bus.note_off,    4'b0000);
        reset_n = 1'b1;
        idle(1);

        // Single allocation and natural expiry exactly HOLD cycles later.
        send(8'h04);
        check("t1_key",    bus.slot_key,    32'h0000_0004);
        check("t1_active", bus.slot_active, 4'b0001);
        check("t1_on",     bus.note_on,     4'b0001);
        idle(9);
        check("t1_off_early",    bus.note_off,    4'b0000);
        check("t1_active_early", bus.slot_active, 4'b0001);
        idle(1);
        check("t1_off",        bus.note_off,    4'b0001);
        check("t1_active_end", bus.slot_active, 4'b0000);
        check("t1_key_end",    bus.slot_key,    32'h0);
        idle(1);
        check("t1_off_pulse", bus.note_off, 4'b0000);

        send(8'h00);
        check("zero_active", bus.slot_active, 4'b0000);
        check("zero_on",     bus.note_on,     4'b0000);

        // Alternate 0x04 / 0x16 every 5 cycles; refresh lands on slot0's expiry cycle.
        on_cnt  = 0;
        off_cnt = 0;
        for (int j = 0; j < 6; j++) begin
            bus.key_valid = 1'b1;
            bus.keycode   = (j % 2 == 0) ? 8'h04 : 8'h16;
            @(negedge clk);
            on_cnt  += $countones(bus.note_on);
            off_cnt += $countones(bus.note_off);
            bus.key_valid = 1'b0;
            bus.keycode   = KEY_NONE;
            repeat (4) begin
                @(negedge clk);
                on_cnt  += $countones(bus.note_on);
                off_cnt += $countones(bus.note_off);
            end
        end
        check("t2_on_count",  on_cnt,          2);
        check("t2_off_count", off_cnt,         0);
        check("t2_active",    bus.slot_active, 4'b0011);
        check("t2_key",       bus.slot_key,    32'h0000_1604);
        pulse_clear(8'h30);
        check("t2_clr_off",    bus.note_off,    4'b0011);
        check("t2_clr_on",     bus.note_on,     4'b0000);
        check("t2_clr_active", bus.slot_active, 4'b0000);

        // Fill all slots, then steal the oldest (smallest timer).
        send(8'h04);
        send(8'h05);
        send(8'h06);
        send(8'h07);
        check("t3_full_key", bus.slot_key, 32'h0706_0504);
        send(8'h08);
        check("t3_steal_on",  bus.note_on,     4'b0001);
        check("t3_steal_off", bus.note_off,    4'b0001);
        check("t3_key",       bus.slot_key,    32'h0706_0508);
        check("t3_active",    bus.slot_active, 4'b1111);
        pulse_clear(8'h00);
        check("t3_clr_off", bus.note_off, 4'b1111);

        // Sustain freezes timers at 9 and 10; expiry resumes from there.
        send(8'h10);
        send(8'h11);
        bus.sustain = 1'b1;
        off_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            off_cnt += $countones(bus.note_off);
        end
        check("t4_sus_off",    off_cnt,         0);
        check("t4_sus_active", bus.slot_active, 4'b0011);
        bus.sustain = 1'b0;
        idle(8);
        check("t4_pre_off",    bus.note_off,    4'b0000);
        check("t4_pre_active", bus.slot_active, 4'b0011);
        idle(1);
        check("t4_off0",    bus.note_off,    4'b0001);
        check("t4_active0", bus.slot_active, 4'b0010);
        idle(1);
        check("t4_off1",    bus.note_off,    4'b0010);
        check("t4_active1", bus.slot_active, 4'b0000);

        // Refresh of slot1 on its expiry edge; clear then lands on slot2's expiry edge.
        send(8'h20);
        send(8'h21);
        send(8'h22);
        idle(2);
        send(8'h20);
        idle(5);
        send(8'h21);
        check("t5_active", bus.slot_active, 4'b0111);
        check("t5_off",    bus.note_off,    4'b0000);
        check("t5_on",     bus.note_on,     4'b0000);
        check("t5_key",    bus.slot_key,    32'h0022_2120);
        pulse_clear(8'h00);
        check("t5_clr_off",    bus.note_off,    4'b0111);
        check("t5_clr_key",    bus.slot_key,    32'h0);
        check("t5_clr_active", bus.slot_active, 4'b0000);

        // Asynchronous reset mid-hold, then fresh allocation into slot0.
        send(8'h04);
        idle(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_active", bus.slot_active, 4'b0000);
        check("t6_rst_key",    bus.slot_key,    32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        send(8'h04);
        check("t6_key",    bus.slot_key,    32'h0000_0004);
        check("t6_on",     bus.note_on,     4'b0001);
        check("t6_off",    bus.note_off,    4'b0000);
        check("t6_active", bus.slot_active, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
